// File: rtl/fpu_pkg.sv
// fpu_pkg: shared binary32 constants, operand layout and squarer state encoding
package fpu_pkg;
  localparam int          FP32_EXP_BIAS = 127;
  localparam logic [31:0] FP32_POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;
  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} fsq_state_t;
endpackage

// File: rtl/fp32_round_pack.sv
// fp32_round_pack: normalises a 48-bit significand product, rounds to nearest-even
// and packs a positive binary32 result with overflow/underflow/inexact flags.
module fp32_round_pack import fpu_pkg::*; (
  input  logic [47:0]       p,
  input  logic signed [9:0] e_res,
  output logic [31:0]       res,
  output logic              ovf,
  output logic              unf,
  output logic              nx
);
  logic              hi, g, s, up;
  logic [22:0]       m;
  logic [23:0]       mr;
  logic signed [9:0] e_n;
  always_comb begin
    hi  = p[47];
    m   = hi ? p[46:24] : p[45:23];
    g   = hi ? p[23] : p[22];
    s   = hi ? |p[22:0] : |p[21:0];
    up  = g & (s | m[0]);
    mr  = {1'b0, m} + 24'(up);
    // mr[23] is the rounding carry: the fraction wraps to zero and the exponent bumps
    e_n = e_res + 10'(hi) + 10'(mr[23]);
    ovf = e_n >= 10'sd255;
    unf = e_n <= 10'sd0;
    nx  = g | s | ovf | unf;
    res = ovf ? FP32_POS_INF : unf ? FP32_POS_ZERO : {1'b0, e_n[7:0], mr[22:0]};
  end
endmodule

// File: rtl/fsquare_seq.sv
// fsquare_seq: iterative binary32 squarer; the significand product is built by a
// radix-2 shift-add loop, one multiplier bit per clock, one operation in flight.
module fsquare_seq import fpu_pkg::*; #(
  parameter int EXP_BIAS = FP32_EXP_BIAS,
  parameter int MANT_W   = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] var1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_nx
);
  localparam int SW = MANT_W + 1;
  localparam int PW = 2 * SW;
  localparam int CW = $clog2(SW);

  fsq_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [SW-1:0]     mant_q, mant_d;
  logic [7:0]        exp_q, exp_d;
  logic [31:0]       res_q, res_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, nx_q, nx_d;
  fp32_t             op;
  logic              unused_sign;
  logic signed [9:0] e_res;
  logic [31:0]       rp_res;
  logic              rp_ovf, rp_unf, rp_nx;

  assign op          = var1;
  assign unused_sign = op.sign;
  assign e_res       = 10'({exp_q, 1'b0}) - 10'(EXP_BIAS);

  fp32_round_pack u_round_pack (
    .p     (acc_q),
    .e_res (e_res),
    .res   (rp_res),
    .ovf   (rp_ovf),
    .unf   (rp_unf),
    .nx    (rp_nx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    nx_d    = nx_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        mant_d  = {1'b1, op.frac};
        exp_d   = op.exp;
        cnt_d   = '0;
        acc_d   = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        nx_d    = 1'b0;
        // zero/subnormal and inf/NaN resolve without touching the multiplier
        res_d   = op.exp == 8'h00 ? FP32_POS_ZERO : op.frac != '0 ? FP32_QNAN : FP32_POS_INF;
        state_d = (op.exp == 8'h00 || op.exp == 8'hFF) ? DONE : MUL;
      end
      MUL: begin
        acc_d   = acc_q + (mant_q[cnt_q] ? PW'(mant_q) << cnt_q : '0);
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(MANT_W) ? NORM : MUL;
      end
      NORM: begin
        res_d   = rp_res;
        ovf_d   = rp_ovf;
        unf_d   = rp_unf;
        nx_d    = rp_nx;
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mant_q  <= '0;
      exp_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      nx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      nx_q    <= nx_d;
    end
  end

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign res       = res_q;
  assign flag_ovf  = ovf_q;
  assign flag_unf  = unf_q;
  assign flag_nx   = nx_q;
endmodule

// File: tb/tb_fsquare_seq.sv
// tb_fsquare_seq: directed vectors with hand-computed squares, latency and handshake checks
module tb_fsquare_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] var1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;
  logic        flag_ovf, flag_unf, flag_nx;
  int          vec = 0;
  int          err = 0;

  fsquare_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .var1      (var1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_nx   (flag_nx)
  );

  always #5 clk = ~clk;

  // edges counts the handshake edge as 1, so 26 means 25 edges after the handshake
  task automatic run_op(input logic [31:0] v, output int edges);
    @(negedge clk);
    in_valid = 1'b1;
    var1     = v;
    @(posedge clk);
    #1 in_valid = 1'b0;
    var1  = 32'hDEADBEEF;
    edges = 1;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1 edges++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    vec++;
    if ({in_ready, out_valid, res, flag_ovf, flag_unf, flag_nx} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
      err++;
      $display("FAIL reset: rdy=%b vld=%b res=%h flags=%b expected rdy=1 vld=0 res=0 flags=000",
               in_ready, out_valid, res, {flag_ovf, flag_unf, flag_nx});
    end
  endtask

  task automatic test_normal();
    int e;
    run_op(32'h40400000, e);
    vec++;
    if (res !== 32'h41100000 || {flag_ovf, flag_unf, flag_nx} !== 3'b000) begin
      err++;
      $display("FAIL square_3.0: res=%h flags=%b expected 41100000 000", res, {flag_ovf, flag_unf, flag_nx});
    end
    vec++;
    if (e !== 26) begin
      err++;
      $display("FAIL latency_normal: edges=%0d expected 26 (handshake + 25)", e);
    end
    consume();
    run_op(32'hC0000000, e);
    vec++;
    if (res !== 32'h40800000 || {flag_ovf, flag_unf, flag_nx} !== 3'b000) begin
      err++;
      $display("FAIL square_-2.0: res=%h flags=%b expected 40800000 000", res, {flag_ovf, flag_unf, flag_nx});
    end
    consume();
  endtask

  task automatic test_rounding();
    int e;
    run_op(32'h3F800001, e);
    vec++;
    if (res !== 32'h3F800002 || {flag_ovf, flag_unf, flag_nx} !== 3'b001) begin
      err++;
      $display("FAIL inexact: res=%h flags=%b expected 3f800002 001", res, {flag_ovf, flag_unf, flag_nx});
    end
    consume();
  endtask

  task automatic test_range();
    logic [31:0] in_t[3]  = '{32'h7F000000, 32'h1F800000, 32'h20000000};
    logic [31:0] exp_t[3] = '{32'h7F800000, 32'h00000000, 32'h00800000};
    logic [2:0]  flg_t[3] = '{3'b101, 3'b011, 3'b000};
    int e;
    for (int i = 0; i < 3; i++) begin
      run_op(in_t[i], e);
      vec++;
      if (res !== exp_t[i] || {flag_ovf, flag_unf, flag_nx} !== flg_t[i]) begin
        err++;
        $display("FAIL range[%0d] in=%h: res=%h flags=%b expected %h %b",
                 i, in_t[i], res, {flag_ovf, flag_unf, flag_nx}, exp_t[i], flg_t[i]);
      end
      consume();
    end
  endtask

  task automatic test_special();
    logic [31:0] in_t[3]  = '{32'h7FC00001, 32'hFF800000, 32'h00000001};
    logic [31:0] exp_t[3] = '{32'h7FC00000, 32'h7F800000, 32'h00000000};
    int e;
    for (int i = 0; i < 3; i++) begin
      run_op(in_t[i], e);
      vec++;
      if (res !== exp_t[i] || {flag_ovf, flag_unf, flag_nx} !== 3'b000 || e !== 1) begin
        err++;
        $display("FAIL special[%0d] in=%h: res=%h flags=%b edges=%0d expected %h 000 edges=1",
                 i, in_t[i], res, {flag_ovf, flag_unf, flag_nx}, e, exp_t[i]);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    int e;
    run_op(32'h40400000, e);
    @(negedge clk);
    in_valid = 1'b1;
    var1     = 32'h3F800000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vec++;
      if ({out_valid, in_ready, res} !== {1'b1, 1'b0, 32'h41100000}) begin
        err++;
        $display("FAIL hold[%0d]: vld=%b rdy=%b res=%h expected vld=1 rdy=0 res=41100000",
                 i, out_valid, in_ready, res);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      err++;
      $display("FAIL release: rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
    end
    run_op(32'h3FC00000, e);
    vec++;
    if (res !== 32'h40100000 || e !== 26) begin
      err++;
      $display("FAIL square_1.5: res=%h edges=%0d expected 40100000 edges=26", res, e);
    end
    consume();
  endtask

  task automatic test_async_reset();
    bit stale = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    var1     = 32'h40400000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({out_valid, res, in_ready} !== {1'b0, 32'h0, 1'b1}) begin
      err++;
      $display("FAIL abort: vld=%b res=%h rdy=%b expected vld=0 res=0 rdy=1", out_valid, res, in_ready);
    end
    #3 rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || !in_ready) stale = 1'b1;
    end
    vec++;
    if (stale) begin
      err++;
      $display("FAIL no_stale: saw out_valid or in_ready=0 after aborted op, expected idle");
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_rounding();
    test_range();
    test_special();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/fsquare_seq.md
Name: fsquare_seq

Overview:
- Iterative single-precision squarer, the inverse operation of the FPU's square-root path.
- Computes res = var1 * var1 in IEEE-754 binary32.
- Mantissa product uses a radix-2 shift-add multiplier, freeing a DSP multiplier for the main datapath.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- EXP_BIAS, 127, binary32 exponent bias.
- MANT_W, 23, stored fraction width; the iteration count is MANT_W+1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand (state IDLE)
- var1  input  32  binary32 operand, sampled on in_valid && in_ready
- out_valid  output  1  res/flags valid
- out_ready  input  1  consumer accepts the result
- res  output  32  binary32 square
- flag_ovf  output  1  overflow to +inf
- flag_unf  output  1  underflow flushed to +0
- flag_nx  output  1  inexact (rounding discarded nonzero bits, or ovf/unf)

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - in_ready=1 once reset is released; out_valid=0; res=32'h0; all flags 0.
  - Reset asserted mid-operation aborts the operation and discards it; no result is produced.
- States:
  - IDLE: in_ready=1. On handshake, latch the operand. A special-case operand goes to DONE; otherwise go to MUL with count=0 and acc=0.
  - MUL: 24 iterations, one per clock. Each cycle: if multiplier bit[count] is set, acc += mcand << count. count increments; at count=23 go to NORM.
  - NORM: one cycle. Normalise, round, pack, then register res and flags. Go to DONE.
  - DONE: out_valid=1. res and flags are held stable until out_ready. On out_valid && out_ready, go to IDLE.
- Latency from the input handshake edge:
  - Normal operand: out_valid rises after 25 clock edges.
  - Special operand: out_valid rises after 1 clock edge.
  - in_ready=0 in MUL, NORM and DONE. The next operand can be accepted the cycle after the output handshake; there is no overlap.
- Arithmetic:
  - The result sign is always 0.
  - Significand m = {1, frac} (24 bits). Product p is 48 bits and lies in [2^46, 2^48).
  - If p[47]=1: the mantissa is p[46:24] and e_res = 2E-127+1. Otherwise the mantissa is p[45:23] and e_res = 2E-127.
  - e_res is computed in 10-bit signed arithmetic.
  - Rounding is round-to-nearest-even on the guard bit and the sticky OR of the discarded bits.
  - A rounding carry-out renormalises: mantissa becomes 0 and e_res increments.
  - After rounding: if e_res >= 255, res=32'h7F800000 with flag_ovf=1 and flag_nx=1.
  - After rounding: if e_res <= 0, res=32'h00000000 with flag_unf=1 and flag_nx=1 (flush-to-zero, no subnormal output).
- Special cases (decoded in IDLE):
  - Exponent 0 (zero or subnormal, flushed): res=+0, no flags.
  - Infinity: res=32'h7F800000, no flags.
  - NaN: res=32'h7FC00000 (canonical quiet NaN), no flags.
- The input operand is ignored while in_ready=0. Asserting in_valid during DONE has no effect.

Decomposition:
- Shared package fpu_pkg holds:
  - FP32_EXP_BIAS, FP32_POS_INF, FP32_QNAN, FP32_POS_ZERO.
  - A typedef fp32_t as a packed struct {sign, exp[7:0], frac[22:0]}.
  - A state enum typedef fsq_state_t {IDLE, MUL, NORM, DONE}.
- One natural sub-module, fp32_round_pack. It is purely combinational: it takes the 48-bit product and e_res, and produces res plus the ovf/unf/nx flags. It is reusable by the other FPU iterative units.

Test Plan:
- var1=32'h40400000 (3.0) -> res=32'h41100000 (9.0), flags 0, out_valid exactly 25 edges after the handshake.
- var1=32'hC0000000 (-2.0) -> res=32'h40800000. Separately, var1=32'h3F800001 -> res=32'h3F800002 with flag_nx=1.
- var1=32'h7F000000 -> res=32'h7F800000 with flag_ovf=1 and flag_nx=1. Separately, var1=32'h1F800000 -> res=32'h0 with flag_unf=1. Separately, var1=32'h20000000 -> res=32'h00800000 with no flags.
- Special operands, each with out_valid after 1 edge: var1=32'h7FC00001 -> res=32'h7FC00000; 32'hFF800000 -> 32'h7F800000; 32'h00000001 -> 32'h0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> res/out_valid stable and in_ready=0. Then raise out_ready -> in_ready=1 on the next cycle, and a back-to-back 1.5 (32'h3FC00000) gives 32'h40100000.
- Pull rst_n low asynchronously at MUL iteration 12 -> out_valid=0 and res=0 immediately. After release, in_ready=1 and no stale result ever appears.
